// File: rtl/gearbox_fifo_wr_arbiter_if.sv
// Requester and FIFO-write bundle for gearbox_fifo_wr_arbiter.
// wdog_err exists only when GBX_ARB_WDOG_EN is defined.
interface gearbox_fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_din;
   logic                          fifo_full;
   logic                          fifo_almost_full;
   logic [IW-1:0]                 grant_id;
   logic                          busy;
`ifdef GBX_ARB_WDOG_EN
   logic                          wdog_err;

   modport master (
      input  req_valid, req_data, fifo_full, fifo_almost_full,
      output req_ready, fifo_wr_en, fifo_din, grant_id, busy, wdog_err
   );
   modport slave (
      output req_valid, req_data, fifo_full, fifo_almost_full,
      input  req_ready, fifo_wr_en, fifo_din, grant_id, busy, wdog_err
   );
`else
   modport master (
      input  req_valid, req_data, fifo_full, fifo_almost_full,
      output req_ready, fifo_wr_en, fifo_din, grant_id, busy
   );
   modport slave (
      output req_valid, req_data, fifo_full, fifo_almost_full,
      input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
   );
`endif
endinterface

// File: rtl/gearbox_fifo_wr_arbiter.sv
// Round-robin burst-locked write arbiter in front of a gearbox FIFO write port.
// Optional stall watchdog enabled by defining GBX_ARB_WDOG_EN.
module gearbox_fifo_wr_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_LEN   = 4,
   parameter int WDOG_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   gearbox_fifo_wr_arbiter_if.master  bus
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

   if (NUM_REQ < 2 || BURST_LEN < 1 || WDOG_CYCLES < 1) begin : g_bad_cfg
      $error("gearbox_fifo_wr_arbiter: illegal parameter set");
   end

   typedef enum logic {IDLE, BURST} state_e;

   state_e                state_q, state_d;
   logic [IW-1:0]         grant_q, grant_d;
   logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
   logic [IW-1:0]         winner;
   logic                  found;
   logic                  own_valid;
   logic [DATA_WIDTH-1:0] own_data;
   logic [IW-1:0]         rr_next;
   logic                  accept;
   logic                  stall_hit;
   logic [NUM_REQ-1:0]    req_ready_c;
   logic                  wr_en_c;
   logic [DATA_WIDTH-1:0] din_c;
   logic                  busy_c;

   // First asserted request at or above rr_ptr, wrapping to 0.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!found && bus.req_valid[idx]) begin
            winner = IW'(idx);
            found  = 1'b1;
         end
      end
   end

   assign own_valid = bus.req_valid[grant_q];
   assign own_data  = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
   assign rr_next   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef GBX_ARB_WDOG_EN
   localparam int SW = $clog2(WDOG_CYCLES + 1);
   logic [SW-1:0] stall_q, stall_d;
   logic          stalling;

   assign stalling  = (state_q == BURST) && bus.fifo_full && own_valid;
   // This cycle is the WDOG_CYCLES-th consecutive stall.
   assign stall_hit = stalling && (stall_q == SW'(WDOG_CYCLES - 1));

   always_comb begin
      stall_d = '0;
      if (stalling && !stall_hit) stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
   end

   assign bus.wdog_err = stall_hit;
`else
   assign stall_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      beat_cnt_d  = beat_cnt_q;
      req_ready_c = '0;
      wr_en_c     = 1'b0;
      din_c       = '0;
      busy_c      = 1'b0;
      accept      = 1'b0;
      case (state_q)
         IDLE: begin
            if (found && !bus.fifo_almost_full) begin
               grant_d    = winner;
               beat_cnt_d = '0;
               state_d    = BURST;
            end
         end
         BURST: begin
            busy_c               = 1'b1;
            req_ready_c[grant_q] = !bus.fifo_full;
            accept               = own_valid && !bus.fifo_full;
            wr_en_c              = accept;
            din_c                = own_data;
            if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
            // Full beat count, owner gone idle, or watchdog abort.
            if ((accept && beat_cnt_q == LAST_BEAT) ||
                (!own_valid && !bus.fifo_full) || stall_hit) begin
               state_d    = IDLE;
               rr_ptr_d   = rr_next;
               beat_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.fifo_wr_en = wr_en_c;
   assign bus.fifo_din   = din_c;
   assign bus.grant_id   = grant_q;
   assign bus.busy       = busy_c;

endmodule
